// File: rtl/qspi_bridge_pkg.sv
// Shared constants for the QSPI bridge: command opcodes and FSM state encoding.
package qspi_bridge_pkg;

    // Command opcodes carried in the first byte of a transaction
    localparam logic [7:0] CMD_RESET = 8'h00;
    localparam logic [7:0] CMD_READ  = 8'h80;

    // Transaction FSM states
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_WRITE  = 3'd2;
    localparam state_t ST_DUMMY  = 3'd3;
    localparam state_t ST_READ   = 3'd4;
    localparam state_t ST_IGNORE = 3'd5;

endpackage

// File: rtl/qspi_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO with a flush input; flush overrides push and pop.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status flags and guarded push/pop; a full FIFO still accepts a push paired with a pop
    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // Pointer next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care while empty so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/qspi_bridge.sv
// Quad-SPI target bridging an MCU master to RX/TX byte FIFOs in the clk domain.
module qspi_bridge
    import qspi_bridge_pkg::*;
#(
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned DUMMY_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       rd_empty,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       wr_full,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       qspi_clk,
    input  logic       qspi_ncs,
    inout  wire  [3:0] qspi_io
);

    localparam logic [7:0] DUMMY_CNT = 8'(DUMMY_BYTES);

    // Synchronizers and edge history
    logic [1:0] sclk_sync_q, ncs_sync_q;
    logic [3:0] io_meta_q, io_sync_q;
    logic       sclk_prev_q, ncs_prev_q;
    logic       sclk_s, ncs_s;
    logic       sclk_rise, sclk_fall, ncs_fall;

    // FSM and datapath state
    state_t     state_q, state_d;
    logic       half_q, half_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic [7:0] dummy_cnt_q, dummy_cnt_d;
    logic       out_half_q, out_half_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       flush_q, flush_d;

    logic       byte_done;
    logic [7:0] rx_byte;
    logic       rx_push, rx_full;
    logic       tx_pop, tx_load, tx_empty;
    logic [7:0] tx_rdata;
    logic       drive_en;
    logic [3:0] out_nib;

    // Two-flop synchronizers; reset low so a select held low across reset is not seen as a fall
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '0;
            io_meta_q   <= '0;
            io_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], qspi_clk};
            ncs_sync_q  <= {ncs_sync_q[0], qspi_ncs};
            io_meta_q   <= qspi_io;
            io_sync_q   <= io_meta_q;
            sclk_prev_q <= sclk_sync_q[1];
            ncs_prev_q  <= ncs_sync_q[1];
        end
    end

    // Edge detection on synchronized pins
    always_comb begin
        sclk_s    = sclk_sync_q[1];
        ncs_s     = ncs_sync_q[1];
        sclk_rise = sclk_s && !sclk_prev_q;
        sclk_fall = !sclk_s && sclk_prev_q;
        ncs_fall  = !ncs_s && ncs_prev_q;
        byte_done = sclk_rise && half_q;
        rx_byte   = {hi_nib_q, io_sync_q};
    end

    // Transaction FSM: nibble assembly, command decode, dummy counting, TX byte loading
    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        hi_nib_d    = hi_nib_q;
        dummy_cnt_d = dummy_cnt_q;
        out_half_d  = out_half_q;
        tx_byte_d   = tx_byte_q;
        flush_d     = 1'b0;
        rx_push     = 1'b0;
        tx_load     = 1'b0;
        tx_pop      = 1'b0;

        if (ncs_s) begin
            // Deselect aborts everything, including a half-received byte
            state_d = ST_IDLE;
            half_d  = 1'b0;
        end else begin
            if (sclk_rise) begin
                half_d = !half_q;
                if (!half_q) hi_nib_d = io_sync_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_d     = ST_CMD;
                        half_d      = 1'b0;
                        dummy_cnt_d = '0;
                        out_half_d  = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_RESET) begin
                            flush_d = 1'b1;
                            state_d = ST_IGNORE;
                        end else if (rx_byte == CMD_READ) begin
                            dummy_cnt_d = '0;
                            state_d     = ST_DUMMY;
                        end else begin
                            rx_push = 1'b1;
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (byte_done) rx_push = 1'b1;
                end
                ST_DUMMY: begin
                    if (dummy_cnt_q == DUMMY_CNT) begin
                        if (sclk_fall) begin
                            tx_load    = 1'b1;
                            out_half_d = 1'b0;
                            state_d    = ST_READ;
                        end
                    end else if (byte_done) begin
                        dummy_cnt_d = dummy_cnt_q + 8'd1;
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        if (!out_half_q) begin
                            out_half_d = 1'b1;
                        end else begin
                            tx_load    = 1'b1;
                            out_half_d = 1'b0;
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // An empty TX FIFO returns 0x00 without popping
        if (tx_load) begin
            if (!tx_empty) begin
                tx_pop    = 1'b1;
                tx_byte_d = tx_rdata;
            end else begin
                tx_byte_d = 8'h00;
            end
        end

        // Overflowing bytes are dropped unless the fabric frees a slot this cycle
        rx_push = rx_push && (!rx_full || rd_en);
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            half_q      <= 1'b0;
            hi_nib_q    <= '0;
            dummy_cnt_q <= '0;
            out_half_q  <= 1'b0;
            tx_byte_q   <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            hi_nib_q    <= hi_nib_d;
            dummy_cnt_q <= dummy_cnt_d;
            out_half_q  <= out_half_d;
            tx_byte_q   <= tx_byte_d;
            flush_q     <= flush_d;
        end
    end

    // Pin driver: only while reading with chip select asserted
    always_comb begin
        drive_en = (state_q == ST_READ) && !ncs_s;
        out_nib  = out_half_q ? tx_byte_q[3:0] : tx_byte_q[7:4];
    end

    assign qspi_io = drive_en ? out_nib : 4'bzzzz;

    sync_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_q),
        .push_i  (rx_push),
        .wdata_i (rx_byte),
        .pop_i   (rd_en),
        .rdata_o (rd_data),
        .empty_o (rd_empty),
        .full_o  (rx_full)
    );

    sync_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_q),
        .push_i  (wr_en),
        .wdata_i (wr_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_rdata),
        .empty_o (tx_empty),
        .full_o  (wr_full)
    );

endmodule

// File: tb/tb_qspi_bridge.sv
// Directed self-checking bench for qspi_bridge with a simple quad-SPI master model.
module tb_qspi_bridge;

    localparam int HALF     = 6;   // clk cycles per qspi_clk half period
    localparam int RX_DEPTH = 16;
    localparam int TX_DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_empty, rd_en;
    logic [7:0] rd_data;
    logic       wr_full, wr_en;
    logic [7:0] wr_data;
    logic       qspi_clk, qspi_ncs;
    wire  [3:0] qspi_io;
    logic       mcu_oe;
    logic [3:0] mcu_nib;

    int n_cmp = 0;
    int n_bad = 0;

    assign qspi_io = mcu_oe ? mcu_nib : 4'bzzzz;
    pullup (qspi_io[0]);
    pullup (qspi_io[1]);
    pullup (qspi_io[2]);
    pullup (qspi_io[3]);

    always #5 clk = ~clk;

    qspi_bridge #(
        .RX_DEPTH    (RX_DEPTH),
        .TX_DEPTH    (TX_DEPTH),
        .DUMMY_BYTES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_empty (rd_empty),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .wr_full  (wr_full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .qspi_clk (qspi_clk),
        .qspi_ncs (qspi_ncs),
        .qspi_io  (qspi_io)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One serial clock pulse; returns the bus value seen just before the rising edge
    task automatic sclk_pulse(output logic [3:0] nib);
        tick(HALF);
        nib = qspi_io;
        qspi_clk = 1'b1;
        tick(HALF);
        qspi_clk = 1'b0;
    endtask

    task automatic mcu_select();
        qspi_ncs = 1'b0;
        tick(HALF);
    endtask

    task automatic mcu_deselect();
        tick(HALF);
        qspi_ncs = 1'b1;
        mcu_oe   = 1'b0;
        tick(4 * HALF);
    endtask

    task automatic mcu_send(input logic [7:0] b);
        logic [3:0] seen;
        mcu_oe  = 1'b1;
        mcu_nib = b[7:4];
        sclk_pulse(seen);
        mcu_nib = b[3:0];
        sclk_pulse(seen);
        mcu_nib = seen;
    endtask

    task automatic mcu_recv(output logic [7:0] b);
        logic [3:0] h, l;
        mcu_oe = 1'b0;
        sclk_pulse(h);
        sclk_pulse(l);
        b = {h, l};
    endtask

    task automatic push_tx(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        tick(1);
        wr_en   = 1'b0;
    endtask

    // Samples head and empty flag, then pops
    task automatic fabric_pop(output logic [7:0] d, output logic e);
        d     = rd_data;
        e     = rd_empty;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        n_cmp++;
        if (rd_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rd_empty: got %0b, required 1", rd_empty);
        end
        n_cmp++;
        if (wr_full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wr_full: got %0b, required 0", wr_full);
        end
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rd_data: got %02h, required 00", rd_data);
        end
        n_cmp++;
        if (qspi_io !== 4'hf) begin
            n_bad++;
            $display("FAIL reset_io_hiz: got %h, required released (f via pullup)", qspi_io);
        end
    endtask

    task automatic test_write();
        logic [7:0] v [4] = '{8'h01, 8'hA5, 8'h3C, 8'hFF};
        logic [7:0] d;
        logic       e;
        mcu_select();
        for (int i = 0; i < 4; i++) mcu_send(v[i]);
        mcu_deselect();
        for (int i = 0; i < 4; i++) begin
            fabric_pop(d, e);
            n_cmp++;
            if (e !== 1'b0 || d !== v[i]) begin
                n_bad++;
                $display("FAIL write_pop%0d: got %02h empty=%0b, required %02h empty=0",
                         i, d, e, v[i]);
            end
        end
        n_cmp++;
        if (rd_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL write_drained: rd_empty=%0b, required 1", rd_empty);
        end
    endtask

    task automatic test_read();
        logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h00};
        logic [7:0] b;
        logic [3:0] nib;
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        mcu_select();
        mcu_send(8'h80);
        mcu_oe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sclk_pulse(nib);
            n_cmp++;
            if (nib !== 4'hf) begin
                n_bad++;
                $display("FAIL read_dummy_hiz%0d: io=%h, required released (f)", i, nib);
            end
        end
        // Fourth byte finds TX empty and must read back as 0x00
        for (int i = 0; i < 4; i++) begin
            mcu_recv(b);
            n_cmp++;
            if (b !== v[i]) begin
                n_bad++;
                $display("FAIL read_byte%0d: got %02h, required %02h", i, b, v[i]);
            end
        end
        mcu_deselect();
        n_cmp++;
        if (qspi_io !== 4'hf) begin
            n_bad++;
            $display("FAIL read_release: io=%h, required released (f)", qspi_io);
        end
    endtask

    task automatic test_flush();
        logic [7:0] b;
        mcu_select();
        for (int i = 1; i <= 5; i++) mcu_send(8'(i));
        mcu_deselect();
        for (int i = 0; i < 5; i++) push_tx(8'hA0 + 8'(i));
        n_cmp++;
        if (rd_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_preload: rd_empty=%0b, required 0", rd_empty);
        end
        mcu_select();
        mcu_send(8'h00);
        mcu_send(8'h77);  // discarded after a RESET command
        mcu_deselect();
        n_cmp++;
        if (rd_empty !== 1'b1 || rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL flush_rx: rd_empty=%0b rd_data=%02h, required 1 and 00",
                     rd_empty, rd_data);
        end
        mcu_select();
        mcu_send(8'h80);
        for (int i = 0; i < 4; i++) mcu_recv(b);
        for (int i = 0; i < 2; i++) begin
            mcu_recv(b);
            n_cmp++;
            if (b !== 8'h00) begin
                n_bad++;
                $display("FAIL flush_tx_read%0d: got %02h, required 00", i, b);
            end
        end
        mcu_deselect();
    endtask

    task automatic test_overflow();
        logic [7:0] d, exp;
        logic       e;
        mcu_select();
        mcu_send(8'h01);
        for (int i = 0; i < RX_DEPTH + 2; i++) mcu_send(8'h10 + 8'(i));
        mcu_deselect();
        for (int j = 0; j < RX_DEPTH; j++) begin
            exp = (j == 0) ? 8'h01 : 8'h10 + 8'(j - 1);
            fabric_pop(d, e);
            n_cmp++;
            if (e !== 1'b0 || d !== exp) begin
                n_bad++;
                $display("FAIL overflow_pop%0d: got %02h empty=%0b, required %02h empty=0",
                         j, d, e, exp);
            end
        end
        n_cmp++;
        if (rd_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_extra_dropped: rd_empty=%0b, required 1", rd_empty);
        end
    endtask

    task automatic test_partial();
        logic [7:0] d;
        logic       e;
        logic [3:0] seen;
        mcu_select();
        mcu_oe  = 1'b1;
        mcu_nib = 4'hA;
        sclk_pulse(seen);
        mcu_deselect();
        n_cmp++;
        if (rd_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_nothing_pushed: rd_empty=%0b, required 1", rd_empty);
        end
        mcu_select();
        mcu_send(8'h42);
        mcu_send(8'h99);
        mcu_deselect();
        fabric_pop(d, e);
        n_cmp++;
        if (e !== 1'b0 || d !== 8'h42) begin
            n_bad++;
            $display("FAIL partial_next0: got %02h empty=%0b, required 42 empty=0", d, e);
        end
        fabric_pop(d, e);
        n_cmp++;
        if (e !== 1'b0 || d !== 8'h99) begin
            n_bad++;
            $display("FAIL partial_next1: got %02h empty=%0b, required 99 empty=0", d, e);
        end
    endtask

    task automatic test_wr_full();
        logic [7:0] b, exp;
        for (int i = 0; i < TX_DEPTH; i++) push_tx(8'h50 + 8'(i));
        n_cmp++;
        if (wr_full !== 1'b1) begin
            n_bad++;
            $display("FAIL txfull_flag: wr_full=%0b, required 1", wr_full);
        end
        push_tx(8'hEE);  // must be ignored
        mcu_select();
        mcu_send(8'h80);
        for (int i = 0; i < 4; i++) mcu_recv(b);
        for (int i = 0; i <= TX_DEPTH; i++) begin
            exp = (i < TX_DEPTH) ? 8'h50 + 8'(i) : 8'h00;
            mcu_recv(b);
            n_cmp++;
            if (b !== exp) begin
                n_bad++;
                $display("FAIL txfull_read%0d: got %02h, required %02h", i, b, exp);
            end
        end
        mcu_deselect();
        n_cmp++;
        if (wr_full !== 1'b0) begin
            n_bad++;
            $display("FAIL txfull_drained: wr_full=%0b, required 0", wr_full);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        qspi_clk = 1'b0;
        qspi_ncs = 1'b1;
        mcu_oe   = 1'b0;
        mcu_nib  = 4'h0;
        test_reset();
        test_write();
        test_read();
        test_flush();
        test_overflow();
        test_partial();
        test_wr_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
